// File: rtl/apb_pkg.sv
// Shared APB types and defaults for the requester-side arbiter
// and the apb_slave register blocks.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_AW_MAX = 32;
  localparam int APB_DW     = 32;
  localparam int APB_AW     = 5;

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Round-robin arbiter: grants the first request after the
// pointer, wrapping; the pointer moves to the winner on advance.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

  // Reset to the last index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (adv_i) begin
      ptr_q <= idx_o;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB bus between NREQ requesters; sequences
// SETUP/ACCESS and aborts hung slaves after TIMEOUT waits.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int DW      = APB_DW,
  parameter int AW      = APB_AW,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [NREQ-1:0]  i_req,
  input  logic [NREQ-1:0]  i_req_write,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_wdata,
  output logic [NREQ-1:0]  o_ack,
  output logic [DW-1:0]    o_rdata,
  output logic             o_err,
  output logic [AW-1:0]    o_paddr,
  output logic             o_pwrite,
  output logic             o_psel,
  output logic             o_penable,
  output logic [DW-1:0]    o_pwdata,
  input  logic [DW-1:0]    i_prdata,
  input  logic             i_pready,
  input  logic             i_pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  if (AW > APB_AW_MAX || NREQ < 2 || NREQ > 8) begin : g_param_err
    $error("apb_master_arbiter: unsupported AW/NREQ");
  end

  apb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_adv;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_write;

  // The requester acked this cycle must not be re-granted at once.
  assign eligible  = i_req & ~ack_q;
  assign arb_adv   = (state_q == IDLE) && (|eligible);
  assign sel_addr  = i_req_addr[arb_idx*AW +: AW];
  assign sel_wdata = i_req_wdata[arb_idx*DW +: DW];
  assign sel_write = i_req_write[arb_idx];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .req_i  (eligible),
    .adv_i  (arb_adv),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwdata_d  = pwdata_q;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d   = SETUP;
          gnt_d     = arb_gnt;
          paddr_d   = sel_addr;
          pwrite_d  = sel_write;
          pwdata_d  = sel_write ? sel_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (i_pready) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = gnt_q;
          rdata_d   = pwrite_q ? '0 : i_prdata;
          err_d     = i_pslverr;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = gnt_q;
          rdata_d   = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign o_ack     = ack_q;
  assign o_rdata   = rdata_q;
  assign o_err     = err_q;
  assign o_paddr   = paddr_q;
  assign o_pwrite  = pwrite_q;
  assign o_psel    = psel_q;
  assign o_penable = penable_q;
  assign o_pwdata  = pwdata_q;

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
APB requester-side controller that shares one APB bus between NREQ local requesters, such as CPU-bridge and DMA ports, and the apb_slave register blocks.
- Arbitrates round-robin between requesters.
- Sequences the APB SETUP/ACCESS phases and waits on PREADY.
- Returns read data and error to the granted requester.
- A wait-state timeout guarantees forward progress against a hung slave.

Parameters:
DW, 32, APB data width
AW, 5, APB address width (max 32)
NREQ, 2, number of requesters (2..8)
TIMEOUT, 16, max ACCESS cycles without PREADY before abort; 0 disables the timeout

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_req  in  NREQ  per-requester transfer request, level; held until its ack
i_req_write  in  NREQ  per-requester direction, 1=write
i_req_addr  in  NREQ*AW  per-requester address, requester k at [k*AW +: AW]
i_req_wdata  in  NREQ*DW  per-requester write data, requester k at [k*DW +: DW]
o_ack  out  NREQ  one-hot, one-cycle completion pulse
o_rdata  out  DW  read data; valid while any o_ack bit is high
o_err  out  1  error flag; valid while any o_ack bit is high
o_paddr  out  AW  APB PADDR
o_pwrite  out  1  APB PWRITE
o_psel  out  1  APB PSEL
o_penable  out  1  APB PENABLE
o_pwdata  out  DW  APB PWDATA
i_prdata  in  DW  APB PRDATA
i_pready  in  1  APB PREADY
i_pslverr  in  1  APB PSLVERR

Behaviour:
- Reset (async assert, sync-release usage): state IDLE, every output 0, grant pointer = NREQ-1 (so requester 0 wins first), timeout counter 0.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: eligible = i_req & ~o_ack, which masks the requester being acked this cycle. If eligible != 0:
    - grant the first eligible index after the pointer, wrapping;
    - latch addr/write/wdata into o_paddr/o_pwrite/o_pwdata (o_pwdata = 0 for reads);
    - set o_psel=1, o_penable=0, pointer=granted index;
    - go to SETUP.
  - SETUP: o_penable<=1, clear counter, go to ACCESS.
  - ACCESS, i_pready=1:
    - o_psel<=0, o_penable<=0;
    - o_ack[grant]<=1;
    - o_rdata<=i_prdata for reads, 0 for writes;
    - o_err<=i_pslverr;
    - go to IDLE.
  - ACCESS, i_pready=0 and TIMEOUT!=0 and counter==TIMEOUT-1: same exit as above, but o_rdata<=0 and o_err<=1 (abort).
  - ACCESS, i_pready=0 otherwise: counter increments; APB address, control and write data are held stable.
- o_ack, o_rdata and o_err are valid for exactly the one IDLE cycle after completion. o_ack clears the next cycle; o_rdata and o_err hold until the next ack.
- Latency:
  - IDLE (request sampled) -> SETUP is 1 cycle; SETUP -> ACCESS is 1 cycle.
  - With PREADY high in the first ACCESS cycle, ack is asserted 3 cycles after the request is sampled.
  - Each wait state adds 1 cycle.
- Transfers never run back-to-back: at least one IDLE cycle (the ack cycle) separates consecutive transfers.
- Payload is captured only in IDLE. Changes to a requester's inputs after grant are ignored. Dropping i_req before its ack does not cancel the transfer; ack still pulses.
- Simultaneous requests are served strictly round-robin. No requester waits more than NREQ-1 transfers.
- Reset asserted mid-transfer: immediate return to reset values with PSEL low. No ack is issued for the killed transfer.
- i_pready and i_pslverr are ignored outside ACCESS.

Decomposition:
- Package apb_pkg:
  - state enum (IDLE, SETUP, ACCESS) in 2 bits;
  - APB_AW_MAX = 32;
  - default DW/AW constants, shared with apb_slave.
- Sub-module rr_arbiter, parameter NREQ:
  - inputs: request vector, advance strobe;
  - outputs: one-hot grant and index;
  - owns the pointer register with async active-low reset.

Test Plan:
- Req0 write addr 0x08 data 0xA5A5_0001, zero-wait slave:
  - PSEL high 2 cycles, PENABLE high in the 2nd;
  - o_ack=2'b01 at cycle 3, o_err=0;
  - a following read of 0x08 returns 0xA5A5_0001.
- Req1 read addr 0x0C against apb_slave (one wait state):
  - ACCESS lasts 2 cycles;
  - o_ack=2'b10 with o_rdata=0xDEAD_BEEF, o_err=0.
- Req0 and req1 both held high from reset, 4 transfers:
  - grant order 0,1,0,1;
  - exactly one IDLE cycle between PSEL pulses.
- Slave holds PREADY=0, TIMEOUT=16:
  - abort after 16 ACCESS cycles;
  - o_ack pulses with o_err=1, o_rdata=0, PSEL drops.
- Write to addr 0x0C (read-only) with PSLVERR=1 at completion: o_err=1 on the ack cycle, o_rdata=0.
- i_reset_n pulsed low during ACCESS of a read:
  - all APB outputs go 0 asynchronously, no ack;
  - after release, a still-pending req0 is granted first and completes normally.
